operand_fetch_stage: RTL and testbench

//  Decode->execute pipeline stage that drives register-file read addresses, takes the

---
 rtl/cpu_types_pkg.sv | 40 ++++
 rtl/operand_fetch_stage_if.sv | 37 +++
 rtl/operand_fetch_stage_fwd_mux.sv | 30 +++
 rtl/operand_fetch_stage.sv | 94 +++++++++
 tb/tb_operand_fetch_stage.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the decode/execute pipeline: widths, control bundle
// and the ID/EX register payload.
package cpu_types_pkg;

   localparam int XLEN   = 64;
   localparam int REG_AW = 5;

   typedef logic [XLEN-1:0]   word_t;
   typedef logic [REG_AW-1:0] regaddr_t;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
   } alu_op_t;

   typedef struct packed {
      alu_op_t alu_op;
      logic    uses_rs1;
      logic    uses_rs2;
      logic    is_load;
      logic    is_store;
      logic    reg_write;
      logic    use_imm;
   } ctrl_t;

   typedef struct packed {
      word_t    pc;
      word_t    imm;
      word_t    op1;
      word_t    op2;
      regaddr_t rd;
      ctrl_t    ctrl;
   } idex_t;

   // A live producer whose destination matches the consumer's source.
   function automatic logic rd_match(input logic v, input regaddr_t rd, input regaddr_t src);
      return v && (rd == src);
   endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Handshake buses around the operand fetch stage: decode -> stage and the
// registered ID/EX bus -> execute.
interface dec_if;
   import cpu_types_pkg::*;

   logic     in_valid;
   logic     in_ready;
   word_t    in_pc;
   regaddr_t in_rs1;
   regaddr_t in_rs2;
   regaddr_t in_rd;
   word_t    in_imm;
   ctrl_t    in_ctrl;

   modport master (output in_valid, in_pc, in_rs1, in_rs2, in_rd, in_imm, in_ctrl,
                   input  in_ready);
   modport slave  (input  in_valid, in_pc, in_rs1, in_rs2, in_rd, in_imm, in_ctrl,
                   output in_ready);
endinterface

interface idex_if;
   import cpu_types_pkg::*;

   logic     out_valid;
   logic     out_ready;
   word_t    out_pc;
   word_t    out_imm;
   word_t    out_op1;
   word_t    out_op2;
   regaddr_t out_rd;
   ctrl_t    out_ctrl;

   modport master (output out_valid, out_pc, out_imm, out_op1, out_op2, out_rd, out_ctrl,
                   input  out_ready);
   modport slave  (input  out_valid, out_pc, out_imm, out_op1, out_op2, out_rd, out_ctrl,
                   output out_ready);
endinterface

// File: rtl/operand_fetch_stage_fwd_mux.sv
// Per-operand forwarding select: x0 forced to zero, then EX (non-load), then MEM,
// then the register file. EX is younger than MEM, so it takes priority.
module fwd_mux
   import cpu_types_pkg::*;
(
   input  regaddr_t src,
   input  word_t    rf_data,
   input  logic     ex_valid,
   input  logic     ex_is_load,
   input  regaddr_t ex_rd,
   input  word_t    ex_data,
   input  logic     mem_valid,
   input  regaddr_t mem_rd,
   input  word_t    mem_data,
   output word_t    op
);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      op = rf_data;
      if (src == '0) begin
         op = '0;
      end else if (rd_match(ex_valid && !ex_is_load, ex_rd, src)) begin
         op = ex_data;
      end else if (rd_match(mem_valid, mem_rd, src)) begin
         op = mem_data;
      end
   end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: regfile read, EX/MEM forwarding, load-use stall and the
// ID/EX pipeline register with valid/ready handshakes on both sides.
module operand_fetch_stage
   import cpu_types_pkg::*;
(
   input  logic     CLK,
   input  logic     nRST,
   dec_if.slave     dec,
   idex_if.master   idex,
   output regaddr_t rf_rs1,
   output regaddr_t rf_rs2,
   input  word_t    rf_rdata1,
   input  word_t    rf_rdata2,
   input  logic     ex_valid,
   input  regaddr_t ex_rd,
   input  logic     ex_is_load,
   input  word_t    ex_data,
   input  logic     mem_valid,
   input  regaddr_t mem_rd,
   input  word_t    mem_data,
   input  logic     flush
);

   word_t op1_fwd;
   word_t op2_fwd;
   logic  hazard;
   logic  advance;
   logic  valid_d, valid_q;
   idex_t idex_d,  idex_q;

   assign rf_rs1 = dec.in_rs1;
   assign rf_rs2 = dec.in_rs2;

   fwd_mux u_fwd_op1 (
      .src(dec.in_rs1), .rf_data(rf_rdata1),
      .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
      .op(op1_fwd)
   );

   fwd_mux u_fwd_op2 (
      .src(dec.in_rs2), .rf_data(rf_rdata2),
      .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
      .op(op2_fwd)
   );

   // A load in EX has no data yet; unused operands never stall.
   assign hazard = ex_valid && ex_is_load && (ex_rd != '0) &&
                   ((dec.in_ctrl.uses_rs1 && (ex_rd == dec.in_rs1)) ||
                    (dec.in_ctrl.uses_rs2 && (ex_rd == dec.in_rs2)));

   assign advance      = !valid_q || idex.out_ready;
   assign dec.in_ready = advance && !hazard && !flush;

   always_comb begin
      valid_d = valid_q;
      idex_d  = idex_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (advance && hazard) begin
         valid_d = 1'b0;
      end else if (advance) begin
         valid_d     = dec.in_valid;
         idex_d.pc   = dec.in_pc;
         idex_d.imm  = dec.in_imm;
         idex_d.op1  = op1_fwd;
         idex_d.op2  = op2_fwd;
         idex_d.rd   = dec.in_rd;
         idex_d.ctrl = dec.in_ctrl;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; the data fields are
   // reset too so the bus reads as zero while idle after reset.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid_q <= 1'b0;
         idex_q  <= '0;
      end else begin
         valid_q <= valid_d;
         idex_q  <= idex_d;
      end
   end

   assign idex.out_valid = valid_q;
   assign idex.out_pc    = idex_q.pc;
   assign idex.out_imm   = idex_q.imm;
   assign idex.out_op1   = idex_q.op1;
   assign idex.out_op2   = idex_q.op2;
   assign idex.out_rd    = idex_q.rd;
   assign idex.out_ctrl  = idex_q.ctrl;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: accepted instructions are pushed to a
// scoreboard with explicit expected operands and popped when EX takes them.
module tb_operand_fetch_stage;
   import cpu_types_pkg::*;

   logic     CLK = 1'b0;
   logic     nRST = 1'b0;
   regaddr_t rf_rs1, rf_rs2;
   word_t    rf_rdata1, rf_rdata2;
   logic     ex_valid, ex_is_load, mem_valid, flush;
   regaddr_t ex_rd, mem_rd;
   word_t    ex_data, mem_data;

   word_t    regs [32];
   idex_t    exp_q [$];
   word_t    exp_op1, exp_op2;
   int       checks = 0;
   int       errors = 0;

   always #5 CLK = ~CLK;

   dec_if  dec ();
   idex_if idex ();

   assign rf_rdata1 = regs[rf_rs1];
   assign rf_rdata2 = regs[rf_rs2];

   operand_fetch_stage dut (
      .CLK(CLK), .nRST(nRST), .dec(dec), .idex(idex),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_data(ex_data),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .flush(flush)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input word_t pc, input regaddr_t rs1, input regaddr_t rs2,
                        input logic u1, input logic u2, input word_t op1, input word_t op2);
      ctrl_t c;
      c          = '0;
      c.alu_op   = ALU_ADD;
      c.uses_rs1 = u1;
      c.uses_rs2 = u2;
      c.reg_write = 1'b1;
      dec.in_valid = 1'b1;
      dec.in_pc    = pc;
      dec.in_rs1   = rs1;
      dec.in_rs2   = rs2;
      dec.in_rd    = regaddr_t'(pc[6:2]);
      dec.in_imm   = pc ^ 64'h0F0F;
      dec.in_ctrl  = c;
      exp_op1      = op1;
      exp_op2      = op2;
   endtask

   // Settle, retire/accept against the scoreboard, then cross one rising edge.
   task automatic tick();
      idex_t e, n;
      #1;
      if (idex.out_valid && idex.out_ready && !flush) begin
         check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_pc",   idex.out_pc,   e.pc);
            check("out_imm",  idex.out_imm,  e.imm);
            check("out_op1",  idex.out_op1,  e.op1);
            check("out_op2",  idex.out_op2,  e.op2);
            check("out_rd",   64'(idex.out_rd),   64'(e.rd));
            check("out_ctrl", 64'(idex.out_ctrl), 64'(e.ctrl));
         end
      end
      if (flush) begin
         exp_q.delete();
      end else if (dec.in_valid && dec.in_ready) begin
         n.pc = dec.in_pc; n.imm = dec.in_imm; n.op1 = exp_op1; n.op2 = exp_op2;
         n.rd = dec.in_rd; n.ctrl = dec.in_ctrl;
         exp_q.push_back(n);
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      word_t snap_pc, snap_op1, snap_op2;
      for (int i = 0; i < 32; i++) regs[i] = 64'h1000 + 64'(i);
      regs[0] = 64'hDEAD;
      regs[1] = 64'h11; regs[3] = 64'h10; regs[4] = 64'h20; regs[5] = 64'h50;
      dec.in_valid = 1'b0; dec.in_pc = '0; dec.in_rs1 = '0; dec.in_rs2 = '0;
      dec.in_rd = '0; dec.in_imm = '0; dec.in_ctrl = '0;
      idex.out_ready = 1'b1;
      ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = '0; ex_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0; flush = 1'b0;
      exp_op1 = '0; exp_op2 = '0;

      // Reset state
      #12;
      check("rst_out_valid", 64'(idex.out_valid), 64'd0);
      check("rst_out_op1", idex.out_op1, 64'd0);
      @(negedge CLK); nRST = 1'b1; #1;
      check("rst_in_ready", 64'(dec.in_ready), 64'd1);
      @(posedge CLK); #1;

      // Plain regfile operands
      issue(64'h100, 5'd3, 5'd4, 1, 1, 64'h10, 64'h20);
      tick();
      check("nohaz_out_valid", 64'(idex.out_valid), 64'd1);

      // EX beats MEM, then MEM alone, then x0 ignores both
      ex_valid = 1; ex_rd = 5'd3; ex_data = 64'hAA;
      mem_valid = 1; mem_rd = 5'd3; mem_data = 64'hBB;
      issue(64'h200, 5'd3, 5'd4, 1, 1, 64'hAA, 64'h20);
      tick();
      ex_valid = 0;
      issue(64'h204, 5'd3, 5'd4, 1, 1, 64'hBB, 64'h20);
      tick();
      ex_valid = 1; ex_rd = 5'd0; ex_data = 64'hCC; mem_rd = 5'd0; mem_data = 64'hDD;
      issue(64'h208, 5'd0, 5'd4, 1, 1, 64'h0, 64'h20);
      tick();

      // Load-use: one bubble, then MEM supplies the load data
      ex_valid = 1; ex_is_load = 1; ex_rd = 5'd5; mem_valid = 0;
      issue(64'h400, 5'd1, 5'd5, 1, 1, 64'h11, 64'h55);
      #1;
      check("lu_in_ready", 64'(dec.in_ready), 64'd0);
      tick();
      check("lu_bubble", 64'(idex.out_valid), 64'd0);
      ex_valid = 0; ex_is_load = 0; mem_valid = 1; mem_rd = 5'd5; mem_data = 64'h55;
      #1;
      check("lu_release", 64'(dec.in_ready), 64'd1);
      tick();
      check("lu_out_valid", 64'(idex.out_valid), 64'd1);

      // Same dependency on an unused operand never stalls
      ex_valid = 1; ex_is_load = 1; ex_rd = 5'd5; mem_valid = 0;
      issue(64'h500, 5'd1, 5'd5, 1, 0, 64'h11, 64'h50);
      #1;
      check("unused_in_ready", 64'(dec.in_ready), 64'd1);
      tick();

      // Backpressure: held output stays put, nothing accepted
      ex_valid = 0; ex_is_load = 0;
      idex.out_ready = 0;
      issue(64'h600, 5'd3, 5'd4, 1, 1, 64'h10, 64'h20);
      snap_pc = idex.out_pc; snap_op1 = idex.out_op1; snap_op2 = idex.out_op2;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_in_ready", 64'(dec.in_ready), 64'd0);
         tick();
         check("bp_valid", 64'(idex.out_valid), 64'd1);
         check("bp_pc", idex.out_pc, snap_pc);
         check("bp_op1", idex.out_op1, snap_op1);
         check("bp_op2", idex.out_op2, snap_op2);
      end
      idex.out_ready = 1;
      tick();

      // Flush under backpressure clears the stage
      idex.out_ready = 0; flush = 1;
      issue(64'h700, 5'd3, 5'd4, 1, 1, 64'h10, 64'h20);
      #1;
      check("flush_in_ready", 64'(dec.in_ready), 64'd0);
      tick();
      check("flush_out_valid", 64'(idex.out_valid), 64'd0);

      // Flush and hazard together
      idex.out_ready = 1; ex_valid = 1; ex_is_load = 1; ex_rd = 5'd3;
      #1;
      check("flush_haz_in_ready", 64'(dec.in_ready), 64'd0);
      tick();
      check("flush_haz_valid", 64'(idex.out_valid), 64'd0);
      flush = 0; ex_valid = 0; ex_is_load = 0;

      // Reset mid-stream drops the registered instruction at once
      issue(64'h800, 5'd3, 5'd4, 1, 1, 64'h10, 64'h20);
      tick();
      check("pre_rst_valid", 64'(idex.out_valid), 64'd1);
      nRST = 0; dec.in_valid = 0; exp_q.delete();
      #1;
      check("mid_rst_valid", 64'(idex.out_valid), 64'd0);
      check("mid_rst_op1", idex.out_op1, 64'd0);
      check("mid_rst_pc", idex.out_pc, 64'd0);
      @(negedge CLK); nRST = 1; #1;
      check("post_rst_in_ready", 64'(dec.in_ready), 64'd1);
      @(posedge CLK); #1;

      // Back-to-back stream, one instruction per cycle
      for (int i = 0; i < 4; i++) begin
         regs[6 + i]  = 64'h3000 + 64'(i);
         regs[12 + i] = 64'h4000 + 64'(i);
      end
      mem_valid = 1; mem_rd = 5'd13; mem_data = 64'h77;
      for (int i = 0; i < 4; i++) begin
         issue(64'h900 + 64'(4 * i), regaddr_t'(6 + i), regaddr_t'(12 + i), 1, 1,
               64'h3000 + 64'(i), (i == 1) ? 64'h77 : 64'h4000 + 64'(i));
         tick();
         check("stream_valid", 64'(idex.out_valid), 64'd1);
      end
      mem_valid = 0; dec.in_valid = 0;
      tick();
      tick();
      check("stream_drained", 64'(exp_q.size()), 64'd0);
      check("idle_valid", 64'(idex.out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
